// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and sizes for the HI/LO multiply/divide unit
// Purpose: op encodings, FSM state enum and default widths used by the
//          hilo_muldiv_unit top, its interface and the testbench.
// Ports:   none (package).
package muldiv_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = $clog2(DATA_W_DEF) + 1;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - request/result bundle between EX stage and the HI/LO unit
// Purpose: groups the start/op/operand request and the busy/done/flag/HI/LO
//          results of hilo_muldiv_unit.
// Ports:   master drives start, op, X, Y and observes busy, done, div_zero, HI, LO;
//          slave is the reverse.
interface hilo_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] X;
  logic [DATA_W-1:0] Y;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output start, op, X, Y,
    input  busy, done, div_zero, HI, LO
  );

  modport slave (
    input  start, op, X, Y,
    output busy, done, div_zero, HI, LO
  );
endinterface

// File: rtl/hilo_iter_core.sv
// rtl/hilo_iter_core.sv - one-step-per-cycle shift-add / restoring shift-subtract datapath
// Purpose: unsigned iterative multiply (acc:sreg = a*b) or divide
//          (sreg = a/b, acc = a%b), one bit per i_step cycle.
// Ports:   clk, rst      clock, synchronous active-high reset
//          i_load        capture i_a/i_b/i_is_div and clear acc/counter
//          i_step        perform one iteration
//          i_is_div      1 = divide, 0 = multiply
//          i_a, i_b      multiplier/dividend, multiplicand/divisor (unsigned)
//          o_last        current step is the final one
//          o_hi, o_lo    accumulator (product hi / remainder), shift reg (product lo / quotient)
module hilo_iter_core #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_last,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_sreg;
  logic [DATA_W-1:0] r_b;
  logic              r_is_div;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shift;
  logic              w_ge;
  logic [DATA_W-1:0] w_diff;

  // Multiply: add b when the low multiplier bit is set, then shift acc:sreg right.
  assign w_sum   = {1'b0, r_acc} + (r_sreg[0] ? {1'b0, r_b} : '0);
  // Divide: shift the next dividend bit into the partial remainder.
  assign w_shift = {r_acc, r_sreg[DATA_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  // When w_ge holds the true difference is below b, so the low DATA_W bits are exact.
  assign w_diff  = w_shift[DATA_W-1:0] - r_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_sreg   <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_sreg   <= i_a;
      r_b      <= i_b;
      r_is_div <= i_is_div;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_is_div) begin
        r_acc  <= w_ge ? w_diff : w_shift[DATA_W-1:0];
        r_sreg <= {r_sreg[DATA_W-2:0], w_ge};
      end else begin
        r_acc  <= w_sum[DATA_W:1];
        r_sreg <= {w_sum[0], r_sreg[DATA_W-1:1]};
      end
    end
  end

  assign o_last = (r_cnt == CNT_W'(DATA_W - 1));
  assign o_hi   = r_acc;
  assign o_lo   = r_sreg;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative MULT/DIV engine owning the HI/LO register pair
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs DATA_W iterations in
//          hilo_iter_core, sign-corrects in FIX and holds results in HI/LO.
// Ports:   clk  rising-edge clock
//          rst  synchronous active-high reset
//          bus  slave side of hilo_muldiv_unit_if (start/op/X/Y in;
//               busy/done/div_zero/HI/LO out)
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  hilo_muldiv_unit_if.slave bus
);

  localparam int STEP_CNT_W = $clog2(DATA_W) + 1;

  state_e            r_state, w_state_nxt;
  logic              r_sign_q, r_sign_r, r_is_div, r_dz, r_done, r_div_zero;
  logic [DATA_W-1:0] r_hi, r_lo;

  logic              w_legal, w_accept, w_signed_op, w_div_op, w_iter_op, w_dz_op;
  logic              w_x_neg, w_y_neg;
  logic              w_load, w_step, w_last;
  logic [DATA_W-1:0] w_abs_x, w_abs_y;
  logic [DATA_W-1:0] w_core_hi, w_core_lo;
  logic [DATA_W-1:0] w_fix_hi, w_fix_lo;
  logic [2*DATA_W-1:0] w_prod_neg;

  assign w_legal     = (bus.op <= OP_MTLO);
  assign w_accept    = (r_state == ST_IDLE) && bus.start && w_legal;
  assign w_iter_op   = !bus.op[2];
  assign w_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign w_div_op    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
  assign w_dz_op     = w_div_op && (bus.Y == '0);
  assign w_x_neg     = w_signed_op && bus.X[DATA_W-1];
  assign w_y_neg     = w_signed_op && bus.Y[DATA_W-1];
  assign w_abs_x     = w_x_neg ? -bus.X : bus.X;
  assign w_abs_y     = w_y_neg ? -bus.Y : bus.Y;

  hilo_iter_core #(
    .DATA_W (DATA_W),
    .CNT_W  (STEP_CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (w_div_op),
    .i_a      (w_abs_x),
    .i_b      (w_abs_y),
    .o_last   (w_last),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept && w_iter_op) begin
          w_load      = 1'b1;
          // Divide by zero skips iteration; FIX writes the defined result.
          w_state_nxt = w_dz_op ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_prod_neg = -{w_core_hi, w_core_lo};

  always_comb begin
    w_fix_hi = w_core_hi;
    w_fix_lo = w_core_lo;
    if (r_dz) begin
      // The core still holds |X| in its shift register; re-apply X's sign to recover X.
      w_fix_hi = r_sign_r ? -w_core_lo : w_core_lo;
      w_fix_lo = '1;
    end else if (r_is_div) begin
      if (r_sign_q) w_fix_lo = -w_core_lo;
      if (r_sign_r) w_fix_hi = -w_core_hi;
    end else if (r_sign_q) begin
      {w_fix_hi, w_fix_lo} = w_prod_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_is_div   <= 1'b0;
      r_dz       <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_div_zero <= 1'b0;
        r_sign_q   <= w_x_neg ^ w_y_neg;
        r_sign_r   <= w_x_neg;
        r_is_div   <= w_div_op;
        r_dz       <= w_dz_op;
        if (bus.op == OP_MTHI) begin
          r_hi   <= bus.X;
          r_done <= 1'b1;
        end
        if (bus.op == OP_MTLO) begin
          r_lo   <= bus.X;
          r_done <= 1'b1;
        end
      end
      if (r_state == ST_FIX) begin
        r_hi       <= w_fix_hi;
        r_lo       <= w_fix_lo;
        r_done     <= 1'b1;
        r_div_zero <= r_dz;
      end
    end
  end

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed-vector bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  hilo_muldiv_unit_if #(.DATA_W(32)) bus ();

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request; returns the cycle offset (T+k) of done and the busy cycle count.
  // b2b=1 drives start in the current (done) cycle; inj_k>0 pulses an MTHI at T+inj_k.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit b2b, input int inj_k,
                        output int done_k, output int busy_n);
    int k;
    if (!b2b) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.X     = x;
    bus.Y     = y;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    done_k = 0;
    busy_n = 0;
    while (k <= 60 && done_k == 0) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_k = k;
      end else begin
        if (k == inj_k) begin
          bus.start = 1'b1;
          bus.op    = OP_MTHI;
          bus.X     = 32'hDEAD_BEEF;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    bus.start = 1'b0;
  endtask

  int dk, bn, cnt_done, cnt_busy;

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.X     = '0;
    bus.Y     = '0;
    repeat (3) @(negedge clk);
    expect_eq("rst_busy", bus.busy, 0);
    expect_eq("rst_done", bus.done, 0);
    expect_eq("rst_dz",   bus.div_zero, 0);
    expect_eq("rst_hilo", {bus.HI, bus.LO}, 64'h0);
    rst = 1'b0;

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0, dk, bn);
    expect_eq("mult_done_k", dk, 34);
    expect_eq("mult_busy_n", bn, 33);
    expect_eq("mult_hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFF1);

    // Start in the done cycle of the previous op.
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, dk, bn);
    expect_eq("b2b_done_k", dk, 34);
    expect_eq("b2b_busy_n", bn, 33);
    expect_eq("multu_hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, dk, bn);
    expect_eq("div_done_k", dk, 34);
    expect_eq("div_hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(OP_DIVU, 32'd100, 32'd7, 0, 0, dk, bn);
    expect_eq("divu_hilo", {bus.HI, bus.LO}, 64'h0000_0002_0000_000E);

    run_op(OP_DIVU, 32'h0000_1234, 32'd0, 0, 0, dk, bn);
    expect_eq("dz_done_k", dk, 2);
    expect_eq("dz_busy_n", bn, 1);
    expect_eq("dz_hilo", {bus.HI, bus.LO}, 64'h0000_1234_FFFF_FFFF);
    expect_eq("dz_flag", bus.div_zero, 1);

    run_op(OP_MTLO, 32'd5, 32'd0, 0, 0, dk, bn);
    expect_eq("mtlo_done_k", dk, 1);
    expect_eq("mtlo_busy_n", bn, 0);
    expect_eq("mtlo_hilo", {bus.HI, bus.LO}, 64'h0000_1234_0000_0005);
    expect_eq("mtlo_dz_clr", bus.div_zero, 0);

    // Illegal op: nothing may change.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b110;
    bus.X     = 32'h0000_00FF;
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) cnt_done++;
      if (bus.busy) cnt_busy++;
    end
    expect_eq("ill_done", cnt_done, 0);
    expect_eq("ill_busy", cnt_busy, 0);
    expect_eq("ill_hilo", {bus.HI, bus.LO}, 64'h0000_1234_0000_0005);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 0, 0, dk, bn);
    expect_eq("sdz_hilo", {bus.HI, bus.LO}, 64'hFFFF_FFF9_FFFF_FFFF);
    expect_eq("sdz_flag", bus.div_zero, 1);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, dk, bn);
    expect_eq("ovf_hilo", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);
    expect_eq("ovf_flag", bus.div_zero, 0);

    // MTHI pulsed while busy must be ignored.
    run_op(OP_MULT, 32'd3, 32'd4, 0, 10, dk, bn);
    expect_eq("inj_done_k", dk, 34);
    expect_eq("inj_hilo", {bus.HI, bus.LO}, 64'h0000_0000_0000_000C);

    // Reset at T+20 of a MULT.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.X     = 32'd7;
    bus.Y     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_eq("mrst_busy", bus.busy, 0);
    expect_eq("mrst_done", bus.done, 0);
    expect_eq("mrst_hilo", {bus.HI, bus.LO}, 64'h0);
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
    end
    expect_eq("mrst_no_done", cnt_done, 0);

    run_op(OP_MTHI, 32'h0000_00AB, 32'd0, 0, 0, dk, bn);
    expect_eq("mthi_done_k", dk, 1);
    expect_eq("mthi_hilo", {bus.HI, bus.LO}, 64'h0000_00AB_0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
